imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 64: instruction-memory depth in 32-bit words.
REQ-002 Parameter ADDR_W, default 6: word-address width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle pulse that begins a load; sampled only in IDLE.
REQ-006 data_in  input  16  halfword from the host stream.
REQ-007 data_valid  input  1  data_in is valid this cycle.
REQ-008 data_ready  output  1  loader accepts data_in this cycle; a transfer occurs only when data_valid and data_ready are both high.
REQ-009 wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 wr_addr  output  ADDR_W  word address for the write.
REQ-011 wr_data  output  32  instruction word for the write.
REQ-012 cpu_hold  output  1  high while a load is in progress; gates the PC/CPU reset.
REQ-013 done  output  1  one-cycle pulse when a load completes.
REQ-014 err  output  1  sticky error flag; cleared by the next start.

Function
REQ-015 FSM states: IDLE, LEN, LO, HI, WRITE, FIN.
- IDLE -> LEN on start.
- LEN: accept one halfword N, the word count.
  - N == 0 -> FIN with no writes.
  - N > DEPTH -> err=1, -> FIN with no writes.
  - Otherwise -> LO.
- LO: accept a halfword into wr_data[15:0], -> HI.
- HI: accept a halfword into wr_data[31:16], -> WRITE.
- WRITE: wr_en=1 for exactly one cycle at wr_addr.
  - wr_addr then increments.
  - After the Nth word -> FIN; otherwise -> LO.
- FIN: done=1 for one cycle, -> IDLE.
REQ-016 data_ready SHALL be high only in LEN, LO and HI; it SHALL be low in IDLE, WRITE and FIN.
REQ-017 In LEN, LO and HI the FSM SHALL stall indefinitely while data_valid is low, holding all outputs.
REQ-018 wr_addr SHALL start at 0 for every load and SHALL increment by 1 after each WRITE; it never wraps because N <= DEPTH.
REQ-019 Timing:
- wr_en SHALL assert the cycle after the HI transfer.
- Minimum cost per word: 3 cycles.
- Load of N words: 2 + 3N cycles from start to done, with data_valid held high.
REQ-020 cpu_hold SHALL be high from the cycle after start through FIN inclusive, and low in IDLE.
REQ-021 start SHALL be ignored outside IDLE; data_valid SHALL be ignored when data_ready is low.
REQ-022 err SHALL clear on the cycle start is accepted in IDLE.

Reset
REQ-023 When rst is low, asynchronously and regardless of state:
- FSM SHALL return to IDLE.
- wr_addr=0, wr_data=0, wr_en=0, data_ready=0, cpu_hold=0, done=0, err=0.
REQ-024 A reset mid-load SHALL abandon the load.
- No further writes occur.
- Words already written are not undone.
REQ-025 After rst deasserts, the block SHALL accept start on the first clock edge.

Configuration
REQ-026 With macro IMEM_LOADER_CHECKSUM_EN defined:
- After the Nth WRITE, the FSM SHALL enter an extra state CHK that accepts one halfword C, then go to FIN.
- err SHALL set if C differs from the mod-2^16 sum of N and all 2N data halfwords.
- data_ready SHALL be high in CHK.
- Load time becomes 3 + 3N cycles (N>0).
REQ-027 Without IMEM_LOADER_CHECKSUM_EN:
- CHK, the checksum accumulator and checksum comparison SHALL not exist.
- err SHALL be set only by N > DEPTH.

Verification
REQ-028 Reset, start, then stream 0x0002,0x0020,0x0123,0x4567,0x89AB -> writes addr0=0x01230020, addr1=0x89AB4567; done 8 cycles after start; err=0.
REQ-029 start, N=0x0000 -> no wr_en; done 2 cycles after start; cpu_hold high for those 2 cycles only.
REQ-030 start, N=DEPTH+1 (0x0041) -> err=1, no wr_en, done pulses; the next start clears err.
REQ-031 Load N=1, data_valid low for 5 cycles between LO and HI -> single write 0xDEADBEEF from halves 0xBEEF,0xDEAD; done at cycle 5+5.
REQ-032 rst low during the third halfword of N=3 -> all outputs 0 immediately; only addr0 written; a fresh load then writes from addr0.
REQ-033 With IMEM_LOADER_CHECKSUM_EN defined, N=1, data 0x0001,0x0002, checksum:
- 0x0004 -> err=0.
- 0x0005 -> err=1.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: halfword host stream -> 32-bit word writes, holds the CPU while loading.
// Latency: 2 + 3N cycles start-to-done (3 + 3N with IMEM_LOADER_CHECKSUM_EN defined), data_valid held high.
// Backpressure: data_ready is high only in LEN/LO/HI (and CHK); the FSM stalls while data_valid is low.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_LO,
        S_HI,
        S_WRITE,
        S_FIN
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] n_last;
    logic              xfer;
    logic              last_word;
    logic              len_zero;
    logic              len_too_big;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [15:0]       csum;
`endif

    assign xfer        = data_valid && data_ready;
    assign last_word   = (wr_addr == n_last);
    assign len_zero    = (data_in == 16'd0);
    assign len_too_big = (data_in > 16'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        data_ready = 1'b0;
        wr_en      = 1'b0;
        done       = 1'b0;
        cpu_hold   = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start) state_d = S_LEN;
            end
            S_LEN: begin
                data_ready = 1'b1;
                if (xfer) state_d = (len_zero || len_too_big) ? S_FIN : S_LO;
            end
            S_LO: begin
                data_ready = 1'b1;
                if (xfer) state_d = S_HI;
            end
            S_HI: begin
                data_ready = 1'b1;
                if (xfer) state_d = S_WRITE;
            end
            S_WRITE: begin
                wr_en = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = last_word ? S_CHK : S_LO;
`else
                state_d = last_word ? S_FIN : S_LO;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                data_ready = 1'b1;
                if (xfer) state_d = S_FIN;
            end
`endif
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // n_last holds N-1, so N == DEPTH maps onto the top address without an extra bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_addr <= '0;
            wr_data <= '0;
            n_last  <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        wr_addr <= '0;
                        err     <= 1'b0;
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        n_last <= data_in[ADDR_W-1:0] - ADDR_W'(1);
                        if (len_too_big) err <= 1'b1;
                    end
                end
                S_LO: begin
                    if (xfer) wr_data[15:0] <= data_in;
                end
                S_HI: begin
                    if (xfer) wr_data[31:16] <= data_in;
                end
                S_WRITE: begin
                    wr_addr <= wr_addr + ADDR_W'(1);
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (xfer && (data_in != csum)) err <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running mod-2^16 sum of the length halfword and every data halfword.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= '0;
        end else if (xfer) begin
            if (state == S_LEN) begin
                csum <= data_in;
            end else if (state == S_LO || state == S_HI) begin
                csum <= csum + data_in;
            end
        end
    end
`endif

endmodule
